// File: rtl/uart_rx.sv
// UART receiver with majority-vote bit sampling at a selectable oversampling ratio.
// Reports each frame as a data_valid, parity_error or stop_error pulse.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  parity_enable,
    input  logic                  Parity_Type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  armed_q, armed_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_err_q, par_err_d;
    logic [5:0]            pres_q, pres_d;
    logic                  pen_q, pen_d;
    logic                  ptype_q, ptype_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [5:0]            eff_prescale;
    logic [5:0]            half;
    logic                  bit_end;
    logic                  maj;
    logic [DATA_WIDTH:0]   shift_in;

    // Unsupported ratios fall back to 8.
    always_comb begin
        eff_prescale = 6'd8;
        case (Prescale)
            6'd8, 6'd16, 6'd32: eff_prescale = Prescale;
            default:            eff_prescale = 6'd8;
        endcase
    end

    assign half     = {1'b0, pres_q[5:1]};
    assign bit_end  = (cnt_q == pres_q - 6'd1);
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                      (samp_q[1] & samp_q[2]);
    assign shift_in = {maj, shift_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        armed_d   = armed_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        pres_d    = pres_q;
        pen_d     = pen_q;
        ptype_d   = ptype_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        if (state_q == StIdle) begin
            if (RX_IN) begin
                armed_d = 1'b1;
            end else if (armed_q) begin
                // This edge is edge 0 of the start bit; frame config is frozen here.
                state_d   = StStart;
                cnt_d     = 6'd1;
                bit_d     = '0;
                armed_d   = 1'b0;
                par_err_d = 1'b0;
                pres_d    = eff_prescale;
                pen_d     = parity_enable;
                ptype_d   = Parity_Type;
            end
        end else begin
            cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
            if (cnt_q == half - 6'd1) samp_d[0] = RX_IN;
            if (cnt_q == half)        samp_d[1] = RX_IN;
            if (cnt_q == half + 6'd1) samp_d[2] = RX_IN;

            if (bit_end) begin
                case (state_q)
                    StStart: begin
                        state_d = maj ? StIdle : StData;
                        bit_d   = '0;
                    end
                    StData: begin
                        shift_d = shift_in[DATA_WIDTH:1];
                        if (bit_q == LastBit) begin
                            state_d = pen_q ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                    StParity: begin
                        if (maj != ((^shift_q) ^ ptype_q)) par_err_d = 1'b1;
                        state_d = StStop;
                    end
                    StStop: begin
                        state_d = StIdle;
                        se_d    = ~maj;
                        pe_d    = par_err_q;
                        // A good stop bit means the line is high: re-arm at once so a
                        // start bit directly after the stop bit is not missed.
                        armed_d = maj;
                        if (maj && !par_err_q) begin
                            dv_d    = 1'b1;
                            pdata_d = shift_q;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            armed_q   <= 1'b0;
            samp_q    <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            pres_q    <= 6'd8;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            armed_q   <= armed_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            pres_q    <= pres_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign data_valid   = dv_q;
    assign parity_error = pe_q;
    assign stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven on the falling edge, pulses
// timestamped on the falling edge and compared against hand-computed values.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       parity_enable;
    logic       Parity_Type;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .parity_enable(parity_enable),
        .Parity_Type  (Parity_Type),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int         dv_cnt = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    int         dv_cyc[64];
    logic [7:0] dv_data[64];
    int         pe_last = 0;
    int         se_last = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc[dv_cnt % 64]  = cyc;
            dv_data[dv_cnt % 64] = P_DATA;
            dv_cnt++;
        end
        if (parity_error) begin
            pe_last = cyc;
            pe_cnt++;
        end
        if (stop_error) begin
            se_last = cyc;
            se_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input bit b, input int p);
        RX_IN = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; t0 is the cycle in which the start bit is first sampled.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit pbit,
                              input bit stop, input bit scramble, output int t0);
        t0 = cyc;
        drive_bit(1'b0, p);
        if (scramble) begin
            Prescale      = 6'd32;
            parity_enable = 1'b1;
            Parity_Type   = 1'b1;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stop, p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, b, pb, sb;

        rst           = 1'b1;
        RX_IN         = 1'b1;
        Prescale      = 6'd8;
        parity_enable = 1'b0;
        Parity_Type   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pdata", 32'(P_DATA), 32'h0);
        check("reset_dv", 32'(data_valid), 32'h0);
        check("reset_pe", 32'(parity_error), 32'h0);
        check("reset_se", 32'(stop_error), 32'h0);
        rst = 1'b0;
        idle(5);

        // P=8, even parity, 0xA5 has four ones -> parity bit 0.
        Prescale = 6'd8; parity_enable = 1'b1; Parity_Type = 1'b0;
        b = dv_cnt; pb = pe_cnt; sb = se_cnt;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        check("a5_dv_count", 32'(dv_cnt - b), 32'd1);
        check("a5_latency", 32'(dv_cyc[b % 64] - t0), 32'd88);
        check("a5_data", 32'(dv_data[b % 64]), 32'hA5);
        check("a5_no_err", 32'((pe_cnt - pb) + (se_cnt - sb)), 32'd0);

        // P=16, no parity, back-to-back frames with no idle gap.
        Prescale = 6'd16; parity_enable = 1'b0;
        b = dv_cnt;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 1'b0, t1);
        idle(4);
        check("b2b_dv_count", 32'(dv_cnt - b), 32'd2);
        check("b2b_latency", 32'(dv_cyc[b % 64] - t0), 32'd160);
        check("b2b_spacing", 32'(dv_cyc[(b + 1) % 64] - dv_cyc[b % 64]), 32'd160);
        check("b2b_data0", 32'(dv_data[b % 64]), 32'h3C);
        check("b2b_data1", 32'(dv_data[(b + 1) % 64]), 32'hFF);

        // Odd parity: 0x01 has one '1', so the correct bit is 0; send 1 to force a mismatch.
        Prescale = 6'd8; parity_enable = 1'b1; Parity_Type = 1'b1;
        b = dv_cnt; pb = pe_cnt; sb = se_cnt;
        send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b0, t0);
        idle(4);
        check("par_pe_count", 32'(pe_cnt - pb), 32'd1);
        check("par_pe_latency", 32'(pe_last - t0), 32'd88);
        check("par_no_dv", 32'(dv_cnt - b), 32'd0);
        check("par_no_se", 32'(se_cnt - sb), 32'd0);
        check("par_pdata_kept", 32'(P_DATA), 32'hFF);

        // Stop bit sampled low.
        parity_enable = 1'b0;
        b = dv_cnt; pb = pe_cnt; sb = se_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        idle(10);
        check("stop_se_count", 32'(se_cnt - sb), 32'd1);
        check("stop_se_latency", 32'(se_last - t0), 32'd80);
        check("stop_no_dv", 32'(dv_cnt - b), 32'd0);
        check("stop_no_pe", 32'(pe_cnt - pb), 32'd0);
        check("stop_pdata_kept", 32'(P_DATA), 32'hFF);

        // 3-cycle glitch at P=16, then a real frame.
        Prescale = 6'd16;
        b = dv_cnt; pb = pe_cnt; sb = se_cnt;
        drive_bit(1'b0, 3);
        idle(40);
        check("glitch_no_pulse", 32'((dv_cnt - b) + (pe_cnt - pb) + (se_cnt - sb)), 32'd0);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        check("glitch_dv_count", 32'(dv_cnt - b), 32'd1);
        check("glitch_latency", 32'(dv_cyc[b % 64] - t0), 32'd160);
        check("glitch_data", 32'(dv_data[b % 64]), 32'h81);

        // Reset mid-frame with the line held low afterwards.
        Prescale = 6'd8; parity_enable = 1'b0;
        b = dv_cnt; pb = pe_cnt; sb = se_cnt;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_pdata_reset", 32'(P_DATA), 32'h0);
        rst = 1'b0;
        drive_bit(1'b0, 20);
        idle(5);
        check("abort_no_pulse", 32'((dv_cnt - b) + (pe_cnt - pb) + (se_cnt - sb)), 32'd0);
        // Unsupported ratio 5 behaves as 8; config changes after the start bit are ignored.
        Prescale = 6'd5;
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1, 1'b1, t0);
        Prescale = 6'd8; parity_enable = 1'b0; Parity_Type = 1'b0;
        idle(6);
        check("abort_dv_count", 32'(dv_cnt - b), 32'd1);
        check("abort_latency", 32'(dv_cyc[b % 64] - t0), 32'd80);
        check("abort_data", 32'(P_DATA), 32'h42);
        check("abort_no_err", 32'((pe_cnt - pb) + (se_cnt - sb)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
